// File: rtl/syn_fifo_flags.sv
// Single-clock FIFO with registered or fall-through read, occupancy count,
// programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module syn_fifo_flags #(
  parameter int unsigned DEP    = 4,
  parameter int unsigned DWID   = 16,
  parameter int unsigned FWFT   = 0,
  parameter int unsigned AF_THR = 3,
  parameter int unsigned AE_THR = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_i,
  input  logic [DWID-1:0]       wdata,
  input  logic                  rd_i,
  input  logic                  clr_err_i,
  output logic [DWID-1:0]       rdata,
  output logic                  rvalid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [$clog2(DEP):0]  count_o,
  output logic                  ovf_err_o,
  output logic                  udf_err_o
);

  localparam int unsigned AW = $clog2(DEP);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]   wrptr;
  logic [PW-1:0]   rdptr;
  logic [PW-1:0]   count;
  logic [DWID-1:0] mem [DEP];
  logic            wr_acc;
  logic            rd_acc;
  logic            ovf_q;
  logic            udf_q;

  // Flags come straight from the count register, so they change only at edges.
  always_comb begin
    full_o         = (count == PW'(DEP));
    empty_o        = (count == '0);
    almost_full_o  = (count >= PW'(AF_THR));
    almost_empty_o = (count <= PW'(AE_THR));
    count_o        = count;
    ovf_err_o      = ovf_q;
    udf_err_o      = udf_q;
  end

  always_comb begin
    wr_acc = wr_i && !full_o && !rst;
    rd_acc = rd_i && !empty_o && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrptr <= '0;
      rdptr <= '0;
      count <= '0;
    end else begin
      if (wr_acc)
        wrptr <= wrptr + PW'(1);
      if (rd_acc)
        rdptr <= rdptr + PW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wrptr[AW-1:0]] <= wdata;
  end

  // Set has priority over clear when both happen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wr_i && full_o)
        ovf_q <= 1'b1;
      else if (clr_err_i)
        ovf_q <= 1'b0;
      if (rd_i && empty_o)
        udf_q <= 1'b1;
      else if (clr_err_i)
        udf_q <= 1'b0;
    end
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [DWID-1:0] rdata_q;
      logic            rvalid_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= rd_acc;
          if (rd_acc)
            rdata_q <= mem[rdptr[AW-1:0]];
        end
      end

      always_comb begin
        rdata    = rdata_q;
        rvalid_o = rvalid_q;
      end
    end else begin : g_fwft_read
      always_comb begin
        rdata    = mem[rdptr[AW-1:0]];
        rvalid_o = !empty_o;
      end
    end
  endgenerate

  // Pointer difference modulo 2*DEP must always equal the occupancy register.
  a_count_matches_ptrs: assert property (@(posedge clk) disable iff (rst)
    count == PW'(wrptr - rdptr));
  a_not_full_and_empty: assert property (@(posedge clk) disable iff (rst)
    !(full_o && empty_o));
  a_count_in_range: assert property (@(posedge clk) disable iff (rst)
    count <= PW'(DEP));

endmodule

// File: tb/tb_syn_fifo_flags.sv
// Bench for syn_fifo_flags: one registered-read and one fall-through instance share
// the stimulus and are checked against a queue-based reference model.
module tb_syn_fifo_flags;

  localparam int DEP  = 4;
  localparam int DWID = 16;
  localparam int AF   = 3;
  localparam int AE   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            wr = 1'b0;
  logic            rd = 1'b0;
  logic            clr = 1'b0;
  logic [DWID-1:0] wdata = '0;

  logic [DWID-1:0] rdata0, rdata1;
  logic            rvalid0, rvalid1, full0, full1, empty0, empty1;
  logic            af0, af1, ae0, ae1, ovf0, ovf1, udf0, udf1;
  logic [2:0]      count0, count1;

  syn_fifo_flags #(.DEP(DEP), .DWID(DWID), .FWFT(0), .AF_THR(AF), .AE_THR(AE)) u_reg (
    .clk(clk), .rst(rst), .wr_i(wr), .wdata(wdata), .rd_i(rd), .clr_err_i(clr),
    .rdata(rdata0), .rvalid_o(rvalid0), .full_o(full0), .empty_o(empty0),
    .almost_full_o(af0), .almost_empty_o(ae0), .count_o(count0),
    .ovf_err_o(ovf0), .udf_err_o(udf0));

  syn_fifo_flags #(.DEP(DEP), .DWID(DWID), .FWFT(1), .AF_THR(AF), .AE_THR(AE)) u_fwft (
    .clk(clk), .rst(rst), .wr_i(wr), .wdata(wdata), .rd_i(rd), .clr_err_i(clr),
    .rdata(rdata1), .rvalid_o(rvalid1), .full_o(full1), .empty_o(empty1),
    .almost_full_o(af1), .almost_empty_o(ae1), .count_o(count1),
    .ovf_err_o(ovf1), .udf_err_o(udf1));

  // Reference model: the FIFO contents as a queue plus the registered-read outputs.
  logic [DWID-1:0] q[$];
  logic [DWID-1:0] m_rdata;
  logic            m_rvalid, m_ovf, m_udf;

  int n_cmp = 0;
  int n_err = 0;

  task automatic model_reset();
    q.delete();
    m_rdata  = '0;
    m_rvalid = 1'b0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
  endtask

  // One clock cycle with the given requests; outputs are sampled 1 ns after the edge.
  task automatic cyc(input logic w, input logic [DWID-1:0] d, input logic r, input logic c);
    bit was_full, was_empty;
    wr = w; wdata = d; rd = r; clr = c;
    @(posedge clk);
    was_full  = (q.size() == DEP);
    was_empty = (q.size() == 0);
    m_rvalid  = 1'b0;
    if (r && !was_empty) begin
      m_rdata  = q.pop_front();
      m_rvalid = 1'b1;
    end
    if (w && !was_full)
      q.push_back(d);
    if (w && was_full) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
    if (r && was_empty) m_udf = 1'b1; else if (c) m_udf = 1'b0;
    #1;
    wr = 1'b0; rd = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr = 1'b1; rd = 1'b1; wdata = 16'h5A5A;
    repeat (2) @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0;
    model_reset();
    n_cmp++; if (count0 !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count0); end
    n_cmp++; if (empty0 !== 1'b1 || full0 !== 1'b0) begin n_err++; $display("FAIL reset_empty_full got=%b%b exp=10", empty0, full0); end
    n_cmp++; if (ae0 !== 1'b1 || af0 !== 1'b0) begin n_err++; $display("FAIL reset_almost got=%b%b exp=10", ae0, af0); end
    n_cmp++; if (rdata0 !== 16'h0 || rvalid0 !== 1'b0) begin n_err++; $display("FAIL reset_rdata got=%h/%b exp=0000/0", rdata0, rvalid0); end
    n_cmp++; if (ovf0 !== 1'b0 || udf0 !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b%b exp=00", ovf0, udf0); end
    n_cmp++; if (rvalid1 !== 1'b0 || empty1 !== 1'b1 || count1 !== 3'd0) begin n_err++; $display("FAIL reset_fwft got=%b%b%0d exp=010", rvalid1, empty1, count1); end
    rst = 1'b0;
    cyc(0, '0, 0, 0);
  endtask

  task automatic test_fill_drain();
    logic [DWID-1:0] vals [4];
    vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 4; i++) begin
      cyc(1, vals[i], 0, 0);
      n_cmp++; if (count0 !== 3'(i + 1)) begin n_err++; $display("FAIL fill_count got=%0d exp=%0d", count0, i + 1); end
      n_cmp++; if (af0 !== (i + 1 >= AF)) begin n_err++; $display("FAIL fill_af got=%b at count %0d", af0, i + 1); end
      n_cmp++; if (ae0 !== (i + 1 <= AE)) begin n_err++; $display("FAIL fill_ae got=%b at count %0d", ae0, i + 1); end
      n_cmp++; if (full0 !== (i == 3)) begin n_err++; $display("FAIL fill_full got=%b at count %0d", full0, i + 1); end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, '0, 1, 0);
      n_cmp++; if (rvalid0 !== 1'b1 || rdata0 !== vals[i]) begin n_err++; $display("FAIL drain_data got=%h/%b exp=%h/1", rdata0, rvalid0, vals[i]); end
      n_cmp++; if (empty0 !== (i == 3)) begin n_err++; $display("FAIL drain_empty got=%b after read %0d", empty0, i); end
    end
    cyc(0, '0, 0, 0);
    n_cmp++; if (rvalid0 !== 1'b0 || rdata0 !== 16'h4444) begin n_err++; $display("FAIL drain_hold got=%h/%b exp=4444/0", rdata0, rvalid0); end
  endtask

  task automatic test_errors();
    for (int i = 0; i < DEP; i++) cyc(1, 16'($urandom), 0, 0);
    cyc(1, 16'hDEAD, 0, 0);
    n_cmp++; if (ovf0 !== 1'b1 || count0 !== 3'd4) begin n_err++; $display("FAIL ovf_set got=%b/%0d exp=1/4", ovf0, count0); end
    cyc(0, '0, 0, 0);
    n_cmp++; if (ovf0 !== 1'b1 || ovf1 !== 1'b1) begin n_err++; $display("FAIL ovf_hold got=%b%b exp=11", ovf0, ovf1); end
    cyc(0, '0, 0, 1);
    n_cmp++; if (ovf0 !== 1'b0) begin n_err++; $display("FAIL ovf_clear got=%b exp=0", ovf0); end
    for (int i = 0; i < DEP; i++) begin
      cyc(0, '0, 1, 0);
      n_cmp++; if (rdata0 !== m_rdata) begin n_err++; $display("FAIL ovf_drain got=%h exp=%h", rdata0, m_rdata); end
    end
    cyc(0, '0, 1, 0);
    n_cmp++; if (udf0 !== 1'b1 || count0 !== 3'd0 || rvalid0 !== 1'b0) begin n_err++; $display("FAIL udf_set got=%b/%0d/%b exp=1/0/0", udf0, count0, rvalid0); end
    cyc(0, '0, 1, 1);
    n_cmp++; if (udf0 !== 1'b1) begin n_err++; $display("FAIL udf_set_wins got=%b exp=1", udf0); end
    cyc(0, '0, 0, 1);
    n_cmp++; if (udf0 !== 1'b0 || udf1 !== 1'b0) begin n_err++; $display("FAIL udf_clear got=%b%b exp=00", udf0, udf1); end
  endtask

  task automatic test_simultaneous();
    cyc(1, 16'hA001, 0, 0);
    cyc(1, 16'hA002, 0, 0);
    cyc(1, 16'hA003, 1, 0);
    n_cmp++; if (count0 !== 3'd2 || rdata0 !== 16'hA001) begin n_err++; $display("FAIL sim_mid got=%0d/%h exp=2/a001", count0, rdata0); end
    cyc(1, 16'hA004, 0, 0);
    cyc(1, 16'hA005, 0, 0);
    cyc(1, 16'hA006, 1, 0);
    n_cmp++; if (count0 !== 3'd3 || rdata0 !== 16'hA002 || ovf0 !== 1'b1) begin n_err++; $display("FAIL sim_full got=%0d/%h/%b exp=3/a002/1", count0, rdata0, ovf0); end
    for (int i = 0; i < 3; i++) begin
      cyc(0, '0, 1, 1);
      n_cmp++; if (rdata0 !== m_rdata) begin n_err++; $display("FAIL sim_drain got=%h exp=%h", rdata0, m_rdata); end
    end
    cyc(1, 16'hA007, 1, 0);
    n_cmp++; if (count0 !== 3'd1 || udf0 !== 1'b1 || rvalid0 !== 1'b0) begin n_err++; $display("FAIL sim_empty got=%0d/%b/%b exp=1/1/0", count0, udf0, rvalid0); end
    cyc(0, '0, 1, 1);
    n_cmp++; if (rdata0 !== 16'hA007 || empty0 !== 1'b1) begin n_err++; $display("FAIL sim_last got=%h/%b exp=a007/1", rdata0, empty0); end
  endtask

  task automatic test_wrap();
    cyc(1, 16'd0, 0, 0);
    for (int v = 1; v < 20; v++) begin
      cyc(1, 16'(v), 1, 0);
      n_cmp++; if (rdata0 !== 16'(v - 1) || rvalid0 !== 1'b1) begin n_err++; $display("FAIL wrap_data got=%0d/%b exp=%0d/1", rdata0, rvalid0, v - 1); end
    end
    cyc(0, '0, 1, 0);
    n_cmp++; if (rdata0 !== 16'd19 || count0 !== 3'd0) begin n_err++; $display("FAIL wrap_last got=%0d/%0d exp=19/0", rdata0, count0); end
  endtask

  task automatic test_fwft();
    cyc(1, 16'hABCD, 0, 0);
    n_cmp++; if (rdata1 !== 16'hABCD || rvalid1 !== 1'b1) begin n_err++; $display("FAIL fwft_show got=%h/%b exp=abcd/1", rdata1, rvalid1); end
    cyc(0, '0, 0, 0);
    n_cmp++; if (rdata1 !== 16'hABCD || rvalid1 !== 1'b1) begin n_err++; $display("FAIL fwft_hold got=%h/%b exp=abcd/1", rdata1, rvalid1); end
    cyc(0, '0, 1, 0);
    n_cmp++; if (rvalid1 !== 1'b0 || empty1 !== 1'b1) begin n_err++; $display("FAIL fwft_pop got=%b/%b exp=0/1", rvalid1, empty1); end
  endtask

  task automatic test_reset_mid();
    cyc(1, 16'h0F01, 0, 0);
    cyc(1, 16'h0F02, 0, 0);
    rst = 1'b1; wr = 1'b1; wdata = 16'hBAD0;
    @(posedge clk);
    #1;
    rst = 1'b0; wr = 1'b0;
    model_reset();
    n_cmp++; if (count0 !== 3'd0 || empty0 !== 1'b1 || rvalid1 !== 1'b0) begin n_err++; $display("FAIL rstmid_state got=%0d/%b/%b exp=0/1/0", count0, empty0, rvalid1); end
    cyc(1, 16'h0F03, 0, 0);
    n_cmp++; if (rdata1 !== 16'h0F03 || count1 !== 3'd1) begin n_err++; $display("FAIL rstmid_fwft got=%h/%0d exp=0f03/1", rdata1, count1); end
    cyc(0, '0, 1, 0);
    n_cmp++; if (rdata0 !== 16'h0F03) begin n_err++; $display("FAIL rstmid_reg got=%h exp=0f03", rdata0); end
  endtask

  task automatic test_random();
    int wr_pct;
    for (int n = 0; n < 600; n++) begin
      wr_pct = ((n / 100) % 2 == 0) ? 75 : 30;
      cyc($urandom_range(99, 0) < wr_pct, 16'($urandom),
          $urandom_range(99, 0) < 50, $urandom_range(15, 0) == 0);
      n_cmp++; if (count0 !== 3'(q.size()) || count1 !== 3'(q.size())) begin n_err++; $display("FAIL rnd_count cyc=%0d got=%0d/%0d exp=%0d", n, count0, count1, q.size()); end
      n_cmp++; if ({full0, empty0, af0, ae0} !== {q.size() == DEP, q.size() == 0, q.size() >= AF, q.size() <= AE}) begin n_err++; $display("FAIL rnd_flags cyc=%0d got=%b%b%b%b size=%0d", n, full0, empty0, af0, ae0, q.size()); end
      n_cmp++; if (ovf0 !== m_ovf || udf0 !== m_udf || ovf1 !== m_ovf || udf1 !== m_udf) begin n_err++; $display("FAIL rnd_err cyc=%0d got=%b%b%b%b exp=%b%b", n, ovf0, udf0, ovf1, udf1, m_ovf, m_udf); end
      n_cmp++; if (rvalid0 !== m_rvalid || rdata0 !== m_rdata) begin n_err++; $display("FAIL rnd_reg cyc=%0d got=%h/%b exp=%h/%b", n, rdata0, rvalid0, m_rdata, m_rvalid); end
      n_cmp++; if (rvalid1 !== (q.size() != 0)) begin n_err++; $display("FAIL rnd_fwft_valid cyc=%0d got=%b size=%0d", n, rvalid1, q.size()); end
      if (q.size() != 0) begin
        n_cmp++; if (rdata1 !== q[0]) begin n_err++; $display("FAIL rnd_fwft_data cyc=%0d got=%h exp=%h", n, rdata1, q[0]); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_drain();
    test_errors();
    test_simultaneous();
    test_wrap();
    test_fwft();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
